// File: rtl/chan_fir_emu.sv
// Runtime-programmable FIR channel model for the emulator clock domain.
// A single time-multiplexed MAC evaluates one tap per cycle, and the output is saturated.
//
// state | meaning
// IDLE  | waiting for cke; tap writes accepted
// MAC   | one tap accumulated per cycle, k = 0 .. N_TAPS-1
// DONE  | result on out, out_valid high; still busy
module chan_fir_emu #(
    parameter int N_TAPS     = 16,
    parameter int IN_WIDTH   = 16,
    parameter int COEF_WIDTH = 16,
    parameter int OUT_WIDTH  = 24,
    parameter int FRAC_SHIFT = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cke,
    input  logic                          bypass,
    input  logic signed [IN_WIDTH-1:0]    in_,
    output logic signed [OUT_WIDTH-1:0]   out,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          overrun,
    input  logic                          coef_we,
    input  logic [$clog2(N_TAPS)-1:0]     coef_addr,
    input  logic signed [COEF_WIDTH-1:0]  coef_wdata,
    output logic                          coef_ready
);
    localparam int K_W    = $clog2(N_TAPS);
    localparam int PROD_W = IN_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + K_W;
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_TAPS - 1);
    localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(1 << FRAC_SHIFT);

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2} state_t;

    state_t                       state, state_nxt;
    logic signed [IN_WIDTH-1:0]   hist [N_TAPS];
    logic signed [COEF_WIDTH-1:0] coef [N_TAPS];
    logic signed [ACC_W-1:0]      acc, acc_sum, in_ext;
    logic signed [PROD_W-1:0]     prod;
    logic [K_W-1:0]               k;
    logic                         take, wr_ok;

    function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > OUT_MAX)
            return OUT_MAX[OUT_WIDTH-1:0];
        else if (v < OUT_MIN)
            return OUT_MIN[OUT_WIDTH-1:0];
        else
            return v[OUT_WIDTH-1:0];
    endfunction

    assign prod    = hist[k] * coef[k];
    assign acc_sum = acc + $signed({{K_W{prod[PROD_W-1]}}, prod});
    assign in_ext  = $signed({{(ACC_W-IN_WIDTH){in_[IN_WIDTH-1]}}, in_});
    assign take    = cke && (state == IDLE);
    assign wr_ok   = coef_we && coef_ready && (int'(coef_addr) < N_TAPS);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cke && !bypass) state_nxt = MAC;
            MAC:     if (k == K_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        coef_ready = (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_TAPS; i++) begin
                hist[i] <= '0;
                coef[i] <= '0;
            end
            coef[0]   <= COEF_ONE;
            acc       <= '0;
            k         <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (cke && busy)
                overrun <= 1'b1;
            if (wr_ok)
                coef[coef_addr] <= coef_wdata;
            if (take) begin
                for (int i = N_TAPS - 1; i > 0; i--)
                    hist[i] <= hist[i-1];
                hist[0] <= in_;
                acc     <= '0;
                k       <= '0;
                if (bypass) begin
                    out       <= sat(in_ext);
                    out_valid <= 1'b1;
                end
            end
            // The last tap folds straight into out so the strobe lands in DONE.
            if (state == MAC) begin
                acc <= acc_sum;
                k   <= k + K_W'(1);
                if (k == K_LAST) begin
                    out       <= sat(acc_sum >>> FRAC_SHIFT);
                    out_valid <= 1'b1;
                end
            end
        end
    end
endmodule
